iob_rr_arbiter: RTL and testbench



---
 rtl/iob_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_iob_rr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter: rotating-priority winner selection with registered one-hot
// grants, held until the owner signals done or an optional hold limit forces release.
module iob_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N-1:0]          req_i,
    input  logic                  done_i,
    output logic [N-1:0]          gnt_o,
    output logic                  gnt_valid_o,
    output logic [$clog2(N)-1:0]  gnt_idx_o,
    output logic                  timeout_o
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] arb_ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] win_hi;
    logic [IW-1:0] win_lo;
    logic          found_hi;
    logic [N-1:0]  gnt_d;
    logic          valid_d;
    logic [IW-1:0] idx_d;
    logic          timeout_d;
    logic          limit_hit;
    logic          release_c;

    // On release the pointer update is not yet visible, so arbitrate from the current owner.
    assign arb_ptr   = (state == GRANT) ? gnt_idx_o : ptr;
    assign release_c = (state == GRANT) && (done_i || limit_hit);

    // Lowest requester above the pointer, else lowest requester overall.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                win_lo = IW'(i);
                if (i > int'(arb_ptr)) begin
                    win_hi   = IW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        win = found_hi ? win_hi : win_lo;
    end

    generate
        if (MAX_HOLD > 0) begin : g_hold
            localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
            logic [HW-1:0] hold_cnt;

            always_ff @(posedge clk_i) begin
                if (rst_i || state != GRANT || release_c) begin
                    hold_cnt <= '0;
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end

            assign limit_hit = (state == GRANT) && (hold_cnt == HW'(MAX_HOLD - 1));
        end else begin : g_no_hold
            assign limit_hit = 1'b0;
        end
    endgenerate

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        gnt_d     = gnt_o;
        valid_d   = gnt_valid_o;
        idx_d     = gnt_idx_o;
        timeout_d = 1'b0;
        case (state)
            IDLE: begin
                if (|req_i) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << win;
                    valid_d = 1'b1;
                    idx_d   = win;
                end
            end
            GRANT: begin
                if (release_c) begin
                    ptr_d     = gnt_idx_o;
                    timeout_d = limit_hit && !done_i;
                    if (|req_i) begin
                        gnt_d   = N'(1) << win;
                        valid_d = 1'b1;
                        idx_d   = win;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ptr         <= IW'(N - 1);
            gnt_o       <= '0;
            gnt_valid_o <= 1'b0;
            gnt_idx_o   <= '0;
            timeout_o   <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            gnt_o       <= gnt_d;
            gnt_valid_o <= valid_d;
            gnt_idx_o   <= idx_d;
            timeout_o   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Randomized and directed bench for iob_rr_arbiter: three configurations
// (N=4 unlimited, N=4 MAX_HOLD=4, N=3 unlimited) checked against a rotation model.
module tb_iob_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req;
    logic       done;

    logic [3:0] gnt_a, gnt_b;
    logic [2:0] gnt_c;
    logic       val_a, val_b, val_c;
    logic [1:0] idx_a, idx_b, idx_c;
    logic       to_a, to_b, to_c;

    int checks = 0;
    int errors = 0;

    iob_rr_arbiter #(.N(4), .MAX_HOLD(0)) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
        .gnt_o(gnt_a), .gnt_valid_o(val_a), .gnt_idx_o(idx_a), .timeout_o(to_a)
    );
    iob_rr_arbiter #(.N(4), .MAX_HOLD(4)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
        .gnt_o(gnt_b), .gnt_valid_o(val_b), .gnt_idx_o(idx_b), .timeout_o(to_b)
    );
    iob_rr_arbiter #(.N(3), .MAX_HOLD(0)) u_c (
        .clk_i(clk), .rst_i(rst), .req_i(req[2:0]), .done_i(done),
        .gnt_o(gnt_c), .gnt_valid_o(val_c), .gnt_idx_o(idx_c), .timeout_o(to_c)
    );

    // Reference model: owner (-1 = none), last owner, cycles the grant has been visible.
    int owner[3];
    int last[3];
    int held[3];
    bit tmo[3];
    int nn[3] = '{4, 4, 3};
    int mh[3] = '{0, 4, 0};

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int k, input logic [3:0] r);
        for (int off = 1; off <= nn[k]; off++) begin
            int c;
            c = (last[k] + off) % nn[k];
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input int k, input logic [3:0] r, input logic d, input logic rs);
        bit lim;
        if (rs) begin
            owner[k] = -1; last[k] = nn[k] - 1; held[k] = 0; tmo[k] = 1'b0;
        end else if (owner[k] < 0) begin
            tmo[k] = 1'b0;
            if (r != 0) begin
                owner[k] = pick(k, r); held[k] = 1;
            end
        end else begin
            lim = (mh[k] > 0) && (held[k] == mh[k]);
            if (d || lim) begin
                tmo[k]  = lim && !d;
                last[k] = owner[k];
                if (r != 0) begin
                    owner[k] = pick(k, r); held[k] = 1;
                end else begin
                    owner[k] = -1; held[k] = 0;
                end
            end else begin
                held[k]++;
                tmo[k] = 1'b0;
            end
        end
    endtask

    task automatic check_inst(input int k, input logic [3:0] g, input logic v,
                              input logic [1:0] i, input logic t);
        int unsigned eg;
        int pos;
        eg = (owner[k] < 0) ? 0 : (1 << owner[k]);
        check($sformatf("gnt%0d", k), g, eg);
        check($sformatf("valid%0d", k), v, (owner[k] < 0) ? 0 : 1);
        check($sformatf("idx%0d", k), i, (owner[k] < 0) ? 0 : owner[k]);
        check($sformatf("timeout%0d", k), t, tmo[k]);
        check($sformatf("onehot%0d", k), $onehot0(g), 1);
        check($sformatf("valid_or%0d", k), v, |g);
        if (v) begin
            pos = 0;
            for (int b = 0; b < 4; b++) if (g[b]) pos = b;
            check($sformatf("idx_pos%0d", k), i, pos);
        end
    endtask

    // Check outputs from the previous edge, then drive and advance the model.
    task automatic apply(input logic [3:0] r, input logic d, input logic rs);
        @(negedge clk);
        check_inst(0, gnt_a, val_a, idx_a, to_a);
        check_inst(1, gnt_b, val_b, idx_b, to_b);
        check_inst(2, {1'b0, gnt_c}, val_c, idx_c, to_c);
        req  = r;
        done = d;
        rst  = rs;
        model_step(0, r, d, rs);
        model_step(1, r, d, rs);
        model_step(2, r & 4'b0111, d, rs);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] r;
        logic       d;
        logic       rs;
        int         exp_seq[5] = '{1, 2, 3, 0, 1};
        int         exp_c[5]   = '{1, 2, 0, 1, 2};

        req = '0; done = 1'b0; rst = 1'b1;
        for (int k = 0; k < 3; k++) model_step(k, 4'b0, 1'b0, 1'b1);
        @(negedge clk);
        apply(4'b0000, 1'b0, 1'b0);

        // Single request, hold without req, release on done.
        apply(4'b0100, 1'b0, 1'b0);
        after_edge();
        check("plan_gnt_0100", gnt_a, 4'b0100);
        check("plan_idx_2", idx_a, 2);
        apply(4'b0000, 1'b0, 1'b0);
        apply(4'b0000, 1'b0, 1'b0);
        apply(4'b0000, 1'b1, 1'b0);
        after_edge();
        check("plan_release_valid", val_a, 0);

        // Full requests with done every grant cycle: back-to-back rotation.
        apply(4'b0000, 1'b0, 1'b1);
        apply(4'b1111, 1'b0, 1'b0);
        after_edge();
        check("plan_rot_first", idx_a, 0);
        for (int s = 0; s < 5; s++) begin
            apply(4'b1111, 1'b1, 1'b0);
            after_edge();
            check("plan_rot", idx_a, exp_seq[s]);
            check("plan_rot_valid", val_a, 1);
            check("plan_rot_n3", idx_c, exp_c[s]);
        end

        // Owner is 1: 1010 goes to 3, then back to 1, then sole requester re-granted.
        apply(4'b1010, 1'b1, 1'b0);
        after_edge();
        check("plan_1010_a", idx_a, 3);
        apply(4'b1010, 1'b1, 1'b0);
        after_edge();
        check("plan_1010_b", idx_a, 1);
        apply(4'b0010, 1'b1, 1'b0);
        after_edge();
        check("plan_sole", gnt_a, 4'b0010);

        // Hold limit on instance b.
        apply(4'b0000, 1'b0, 1'b1);
        for (int s = 0; s < 4; s++) begin
            apply(4'b0011, 1'b0, 1'b0);
            after_edge();
            check("plan_hold_gnt", gnt_b, 4'b0001);
            check("plan_hold_to", to_b, 0);
        end
        apply(4'b0011, 1'b0, 1'b0);
        after_edge();
        check("plan_limit_gnt", gnt_b, 4'b0010);
        check("plan_limit_to", to_b, 1);
        apply(4'b0011, 1'b0, 1'b0);
        apply(4'b0011, 1'b0, 1'b0);
        apply(4'b0011, 1'b1, 1'b0);
        after_edge();
        check("plan_done_at_limit_to", to_b, 0);
        check("plan_done_at_limit_gnt", gnt_b, 4'b0001);

        // Reset mid-grant, then ptr must favour requester 0.
        apply(4'b0000, 1'b0, 1'b1);
        apply(4'b1000, 1'b0, 1'b0);
        apply(4'b1000, 1'b0, 1'b1);
        after_edge();
        check("plan_rst_gnt", gnt_a, 0);
        apply(4'b1001, 1'b0, 1'b0);
        after_edge();
        check("plan_rst_ptr", gnt_a, 4'b0001);

        // done in IDLE is ignored.
        apply(4'b0000, 1'b0, 1'b1);
        apply(4'b0000, 1'b1, 1'b0);
        after_edge();
        check("plan_idle_done", {val_a, gnt_a}, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            r  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = 4'b0;
            d  = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 63) == 0);
            apply(r, d, rs);
        end
        apply(4'b0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
